// File: rtl/tlb_pkg.sv
// tlb_pkg: shared widths, Sv32 entry field offsets and sequencer states for the TLB refill controller.
package tlb_pkg;
   localparam int VPN_W     = 20;
   localparam int PPN_W     = 22;
   localparam int TLB_DEPTH = 32;
   localparam int IDX_W     = 5;
   localparam int ENTRY_W   = VPN_W + 32;
   localparam int F_V       = 0;
   localparam int F_R       = 1;
   localparam int F_W       = 2;
   localparam int F_X       = 3;
   localparam int F_U       = 4;
   localparam int PPN_LO    = 10;
   localparam int PPN_HI    = 31;
   localparam int VPN_LO    = 32;
   localparam int VPN_HI    = 51;
   typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, WALK, REFILL, FLUSH} state_t;
endpackage

// File: rtl/tlb_victim_ptr.sv
// tlb_victim_ptr: round-robin refill slot pointer, cleared when a flush completes.
module tlb_victim_ptr
   import tlb_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [IDX_W-1:0] o_idx
);
   logic [IDX_W-1:0] r_idx;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_idx <= '0;
      else     r_idx <= i_clr ? '0 : (i_inc ? r_idx + IDX_W'(1) : r_idx);
   assign o_idx = r_idx;
endmodule

// File: rtl/tlb_refill_ctrl.sv
// tlb_refill_ctrl: lookup / page-walk refill / flush sequencer for a 32-entry Sv32 TLB CAM.
// Optional TLB_PERF_CNT_EN adds saturating hit_count / miss_count outputs.
module tlb_refill_ctrl
   import tlb_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   input  logic [VPN_W-1:0]   req_vpn,
   output logic               req_ready,
   output logic               resp_valid,
   output logic [PPN_W-1:0]   resp_ppn,
   output logic [3:0]         resp_perm,
   output logic               resp_fault,
   input  logic               flush_req,
   output logic               flush_done,
   output logic               tlb_re,
   output logic [VPN_W-1:0]   tlb_vpn,
   input  logic               tlb_miss,
   input  logic               tlb_valid_data,
   input  logic [PPN_W+3:0]   tlb_data,
   output logic               tlb_we,
   output logic [IDX_W-1:0]   tlb_waddr,
   output logic [ENTRY_W-1:0] tlb_wdata,
   output logic               ptw_req,
   output logic [VPN_W-1:0]   ptw_vpn,
   input  logic               ptw_ack,
   input  logic [31:0]        ptw_pte,
   input  logic               ptw_fault
`ifdef TLB_PERF_CNT_EN
   ,
   output logic [31:0]        hit_count,
   output logic [31:0]        miss_count
`endif
);
   state_t           r_state, w_next;
   logic [VPN_W-1:0] r_vpn;
   logic [31:0]      r_pte;
   logic             r_replay;
   logic [IDX_W-1:0] r_flush_cnt, w_victim;
   logic             r_resp_valid, r_resp_fault;
   logic [PPN_W-1:0] r_resp_ppn;
   logic [3:0]       r_resp_perm;
   logic             w_rsp, w_hit, w_walk, w_refill, w_flush, w_last;

   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;

   always_comb begin
      w_next     = r_state;
      w_rsp      = 1'b0;
      w_hit      = 1'b0;
      w_walk     = 1'b0;
      w_refill   = r_state == REFILL;
      w_flush    = r_state == FLUSH;
      w_last     = w_flush && r_flush_cnt == IDX_W'(TLB_DEPTH - 1);
      req_ready  = r_state == IDLE && !flush_req;
      tlb_re     = r_state == LOOKUP;
      tlb_vpn    = tlb_re ? r_vpn : '0;
      ptw_req    = r_state == WALK;
      ptw_vpn    = ptw_req ? r_vpn : '0;
      tlb_we     = w_refill || w_flush;
      tlb_waddr  = w_flush ? r_flush_cnt : (w_refill ? w_victim : '0);
      tlb_wdata  = w_refill ? {r_vpn, r_pte} : '0;
      flush_done = w_last;
      case (r_state)
         IDLE:   w_next = flush_req ? FLUSH : (req_valid ? LOOKUP : IDLE);
         LOOKUP: w_next = CHECK;
         CHECK: begin
            w_hit  = tlb_valid_data;
            w_rsp  = tlb_valid_data || r_replay;
            w_walk = !tlb_valid_data && (tlb_miss || !r_replay) && !r_replay;
            w_next = w_rsp ? IDLE : WALK;
         end
         WALK: begin
            w_rsp  = ptw_ack && (ptw_fault || !ptw_pte[F_V]);
            w_next = !ptw_ack ? WALK : (w_rsp ? IDLE : REFILL);
         end
         REFILL: w_next = LOOKUP;
         FLUSH:  w_next = w_last ? IDLE : FLUSH;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_vpn        <= '0;
         r_pte        <= '0;
         r_replay     <= 1'b0;
         r_flush_cnt  <= '0;
         r_resp_valid <= 1'b0;
         r_resp_ppn   <= '0;
         r_resp_perm  <= '0;
         r_resp_fault <= 1'b0;
      end else begin
         r_resp_valid <= w_rsp;
         if (w_rsp) begin
            r_resp_ppn   <= w_hit ? tlb_data[PPN_W+3:4] : '0;
            r_resp_perm  <= w_hit ? tlb_data[3:0] : '0;
            r_resp_fault <= !w_hit;
         end
         if (r_state == IDLE && w_next == LOOKUP) r_vpn <= req_vpn;
         if (ptw_req && ptw_ack) r_pte <= ptw_pte;
         // the replay flag marks the second lookup after a refill
         r_replay    <= (w_next == IDLE) ? 1'b0 : (w_refill ? 1'b1 : r_replay);
         r_flush_cnt <= w_flush ? r_flush_cnt + IDX_W'(1) : '0;
      end

   assign resp_valid = r_resp_valid;
   assign resp_ppn   = r_resp_ppn;
   assign resp_perm  = r_resp_perm;
   assign resp_fault = r_resp_fault;

   tlb_victim_ptr u_victim (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_refill),
      .i_clr (w_last),
      .o_idx (w_victim)
   );

`ifdef TLB_PERF_CNT_EN
   logic [31:0] r_hit_cnt, r_miss_cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_hit && ~&r_hit_cnt)   r_hit_cnt  <= r_hit_cnt + 32'd1;
         if (w_walk && ~&r_miss_cnt) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   assign hit_count  = r_hit_cnt;
   assign miss_count = r_miss_cnt;
`endif
endmodule
